// File: rtl/pixel_writer_pkg.sv
// Shared definitions for the pixel write path and the display read-out side.
// Holds the write-side state type, default frame-buffer geometry and a counter helper.
package pixel_writer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } wr_state_t;

  localparam int FB_WIDTH_DEF    = 320;
  localparam int FB_HEIGHT_DEF   = 180;
  localparam int SCALE_SHIFT_DEF = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with a registered read port.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module pixel_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == (PTR_W + 1)'(DEPTH));
  assign empty     = (count_r == {(PTR_W + 1){1'b0}});
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage array, no reset needed
  always_ff @(posedge clk_in) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered read data
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W + 1){1'b0}};
      dout     <= {WIDTH{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        dout     <= mem_r[rd_ptr_r];
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/pixel_writer.sv
// Clips and downscales painter coordinates, buffers them and writes them to the frame buffer.
// A clear sweep takes the write port; pixels arriving meanwhile wait in the FIFO.
module pixel_writer
  import pixel_writer_pkg::*;
#(
  parameter int FB_WIDTH    = FB_WIDTH_DEF,
  parameter int FB_HEIGHT   = FB_HEIGHT_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int COLOR_W     = 8,
  parameter int CLEAR_COLOR = 0,
  parameter int FIFO_DEPTH  = 16,
  parameter int ADDR_W      = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               data_valid_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               clear_in,
  output logic [ADDR_W-1:0]  fb_addr_out,
  output logic [COLOR_W-1:0] fb_data_out,
  output logic               fb_we_out,
  output logic               busy_out,
  output logic [15:0]        drop_count_out,
  output logic [15:0]        clip_count_out
);

  localparam int                ENTRY_W   = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

  logic [10:0]        col_s;
  logic [9:0]         row_s;
  logic               in_range_s;
  logic               s0_valid_r;
  logic [10:0]        s0_col_r;
  logic [9:0]         s0_row_r;
  logic [COLOR_W-1:0] s0_color_r;
  logic               s1_valid_r;
  logic [ADDR_W-1:0]  s1_prod_r;
  logic [10:0]        s1_col_r;
  logic [COLOR_W-1:0] s1_color_r;
  logic [ADDR_W-1:0]  push_addr_s;
  logic [ENTRY_W-1:0] fifo_din_s;
  logic [ENTRY_W-1:0] fifo_dout_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               drop_s;

  wr_state_t          state_r;
  wr_state_t          state_nx_s;
  logic [ADDR_W-1:0]  clr_cnt_r;
  logic               pop_s;
  logic               pop_d_r;
  logic               fb_we_s;
  logic [ADDR_W-1:0]  fb_addr_s;
  logic [COLOR_W-1:0] fb_data_s;
  logic               busy_s;

  assign col_s       = hcount_in >> SCALE_SHIFT;
  assign row_s       = vcount_in >> SCALE_SHIFT;
  assign in_range_s  = (col_s < 11'(FB_WIDTH)) && (row_s < 10'(FB_HEIGHT));
  assign push_addr_s = s1_prod_r + ADDR_W'(s1_col_r);
  assign fifo_din_s  = {push_addr_s, s1_color_r};
  // The stored entry is lost only if no pop frees a slot this cycle
  assign drop_s      = s1_valid_r && fifo_full_s && !pop_s;

  // Clip/scale stage and row-offset multiply stage
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s0_valid_r <= 1'b0;
      s0_col_r   <= 11'd0;
      s0_row_r   <= 10'd0;
      s0_color_r <= {COLOR_W{1'b0}};
      s1_valid_r <= 1'b0;
      s1_prod_r  <= {ADDR_W{1'b0}};
      s1_col_r   <= 11'd0;
      s1_color_r <= {COLOR_W{1'b0}};
    end else begin
      s0_valid_r <= data_valid_in && in_range_s;
      s0_col_r   <= col_s;
      s0_row_r   <= row_s;
      s0_color_r <= color_in;
      s1_valid_r <= s0_valid_r;
      s1_prod_r  <= ADDR_W'(s0_row_r) * ADDR_W'(FB_WIDTH);
      s1_col_r   <= s0_col_r;
      s1_color_r <= s0_color_r;
    end
  end

  pixel_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .push  (s1_valid_r),
    .pop   (pop_s),
    .din   (fifo_din_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .dout  (fifo_dout_s)
  );

  // Saturating debug counters
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clip_count_out <= 16'd0;
      drop_count_out <= 16'd0;
    end else begin
      if (data_valid_in && !in_range_s) begin
        clip_count_out <= sat_inc16(clip_count_out);
      end
      if (drop_s) begin
        drop_count_out <= sat_inc16(drop_count_out);
      end
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; a clear request during a sweep is ignored
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (clear_in) begin
          state_nx_s = CLEAR;
        end else begin
          state_nx_s = IDLE;
        end
      end
      CLEAR: begin
        if (clr_cnt_r == LAST_ADDR) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = CLEAR;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Output decode: pop request and next write-port values
  always_comb begin
    pop_s     = 1'b0;
    fb_we_s   = 1'b0;
    fb_addr_s = fb_addr_out;
    fb_data_s = fb_data_out;
    busy_s    = 1'b0;
    case (state_r)
      IDLE: begin
        pop_s = !clear_in && !fifo_empty_s;
        if (pop_d_r) begin
          fb_we_s   = 1'b1;
          fb_addr_s = fifo_dout_s[ENTRY_W-1:COLOR_W];
          fb_data_s = fifo_dout_s[COLOR_W-1:0];
        end else begin
          fb_we_s = 1'b0;
        end
      end
      CLEAR: begin
        busy_s    = 1'b1;
        fb_we_s   = 1'b1;
        fb_addr_s = clr_cnt_r;
        fb_data_s = COLOR_W'(CLEAR_COLOR);
      end
      default: begin
        pop_s   = 1'b0;
        fb_we_s = 1'b0;
      end
    endcase
  end

  // Sweep address counter and registered write port
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      clr_cnt_r   <= {ADDR_W{1'b0}};
      pop_d_r     <= 1'b0;
      fb_addr_out <= {ADDR_W{1'b0}};
      fb_data_out <= {COLOR_W{1'b0}};
      fb_we_out   <= 1'b0;
      busy_out    <= 1'b0;
    end else begin
      if ((state_r == CLEAR) && (clr_cnt_r != LAST_ADDR)) begin
        clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
      end else begin
        clr_cnt_r <= {ADDR_W{1'b0}};
      end
      pop_d_r     <= pop_s;
      fb_addr_out <= fb_addr_s;
      fb_data_out <= fb_data_s;
      fb_we_out   <= fb_we_s;
      busy_out    <= busy_s;
    end
  end

endmodule

// File: tb/tb_pixel_writer.sv
// Directed self-checking bench for pixel_writer with default geometry (320x180, shift 2).
module tb_pixel_writer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = 11'd0;
  logic [9:0]  vcount_in = 10'd0;
  logic        data_valid_in = 1'b0;
  logic [7:0]  color_in = 8'd0;
  logic        clear_in = 1'b0;
  logic [15:0] fb_addr_out;
  logic [7:0]  fb_data_out;
  logic        fb_we_out;
  logic        busy_out;
  logic [15:0] drop_count_out;
  logic [15:0] clip_count_out;

  int pass_cnt  = 0;
  int total_cnt = 0;

  pixel_writer dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .data_valid_in (data_valid_in),
    .color_in      (color_in),
    .clear_in      (clear_in),
    .fb_addr_out   (fb_addr_out),
    .fb_data_out   (fb_data_out),
    .fb_we_out     (fb_we_out),
    .busy_out      (busy_out),
    .drop_count_out(drop_count_out),
    .clip_count_out(clip_count_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    step();
    step();
    total_cnt++;
    if (fb_addr_out !== 16'd0 || fb_data_out !== 8'd0 || fb_we_out !== 1'b0)
      $display("FAIL reset_port: addr=%0d data=%h we=%b, expected 0/00/0", fb_addr_out, fb_data_out, fb_we_out);
    else pass_cnt++;
    total_cnt++;
    if (busy_out !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_out);
    else pass_cnt++;
    total_cnt++;
    if (drop_count_out !== 16'd0 || clip_count_out !== 16'd0)
      $display("FAIL reset_counts: drop=%0d clip=%0d expected 0/0", drop_count_out, clip_count_out);
    else pass_cnt++;
    rst_in = 1'b1;
    step();
  endtask

  task automatic test_single_pixel();
    hcount_in = 11'd100; vcount_in = 10'd40; color_in = 8'h5A; data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total_cnt++;
      if (fb_we_out !== 1'b0) $display("FAIL single_early: we=%b at +%0d expected 0", fb_we_out, i);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (fb_we_out !== 1'b1 || fb_addr_out !== 16'd3225 || fb_data_out !== 8'h5A)
      $display("FAIL single_write: we=%b addr=%0d data=%h expected 1/3225/5a", fb_we_out, fb_addr_out, fb_data_out);
    else pass_cnt++;
    step();
    total_cnt++;
    if (fb_we_out !== 1'b0) $display("FAIL single_once: we=%b expected 0", fb_we_out);
    else pass_cnt++;
  endtask

  task automatic test_clipping();
    hcount_in = 11'd1280; vcount_in = 10'd0; color_in = 8'h11; data_valid_in = 1'b1;
    step();
    hcount_in = 11'd0; vcount_in = 10'd720;
    step();
    data_valid_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      total_cnt++;
      if (fb_we_out !== 1'b0) $display("FAIL clip_nowrite: we=%b cycle %0d expected 0", fb_we_out, i);
      else pass_cnt++;
    end
    total_cnt++;
    if (clip_count_out !== 16'd2) $display("FAIL clip_count: got %0d expected 2", clip_count_out);
    else pass_cnt++;
    hcount_in = 11'd1279; vcount_in = 10'd719; color_in = 8'h33; data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
    step(); step(); step(); step();
    total_cnt++;
    if (fb_we_out !== 1'b1 || fb_addr_out !== 16'd57599 || fb_data_out !== 8'h33)
      $display("FAIL clip_corner: we=%b addr=%0d data=%h expected 1/57599/33", fb_we_out, fb_addr_out, fb_data_out);
    else pass_cnt++;
    total_cnt++;
    if (clip_count_out !== 16'd2) $display("FAIL clip_count_after: got %0d expected 2", clip_count_out);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    logic exp_we;
    logic ok;
    for (int c = 0; c < 210; c++) begin
      if (c < 200) begin
        data_valid_in = 1'b1; hcount_in = 11'(c * 4); vcount_in = 10'd8; color_in = 8'(c);
      end else begin
        data_valid_in = 1'b0;
      end
      step();
      exp_we = (c >= 4) && (c < 204);
      ok = (fb_we_out === exp_we) &&
           (!exp_we || (fb_addr_out === 16'(640 + c - 4) && fb_data_out === 8'(c - 4)));
      total_cnt++;
      if (!ok)
        $display("FAIL stream: cycle %0d we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                 c, fb_we_out, fb_addr_out, fb_data_out, exp_we, 640 + c - 4, 8'(c - 4));
      else pass_cnt++;
    end
    total_cnt++;
    if (drop_count_out !== 16'd0) $display("FAIL stream_drop: got %0d expected 0", drop_count_out);
    else pass_cnt++;
  endtask

  task automatic test_clear_overflow();
    int sweep_err;
    int first_bad;
    sweep_err = 0;
    first_bad = -1;
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    total_cnt++;
    if (busy_out !== 1'b0 || fb_we_out !== 1'b0)
      $display("FAIL clear_start: busy=%b we=%b expected 0/0", busy_out, fb_we_out);
    else pass_cnt++;
    for (int e = 1; e <= 57600; e++) begin
      if (e <= 20) begin
        data_valid_in = 1'b1; hcount_in = 11'((e - 1) * 4); vcount_in = 10'd20;
        color_in = 8'(8'hA0 + e - 1);
      end else begin
        data_valid_in = 1'b0;
      end
      clear_in = (e == 30000);
      step();
      if (busy_out !== 1'b1 || fb_we_out !== 1'b1 || fb_addr_out !== 16'(e - 1) || fb_data_out !== 8'h00) begin
        sweep_err++;
        if (first_bad < 0) first_bad = e - 1;
      end
    end
    clear_in = 1'b0;
    total_cnt++;
    if (sweep_err !== 0)
      $display("FAIL clear_sweep: %0d bad cycles (first at index %0d), expected 0", sweep_err, first_bad);
    else pass_cnt++;
    step();
    total_cnt++;
    if (busy_out !== 1'b0 || fb_we_out !== 1'b0)
      $display("FAIL clear_end: busy=%b we=%b expected 0/0", busy_out, fb_we_out);
    else pass_cnt++;
    total_cnt++;
    if (drop_count_out !== 16'd4) $display("FAIL overflow_drop: got %0d expected 4", drop_count_out);
    else pass_cnt++;
    for (int k = 0; k < 16; k++) begin
      step();
      total_cnt++;
      if (fb_we_out !== 1'b1 || fb_addr_out !== 16'(1600 + k) || fb_data_out !== 8'(8'hA0 + k))
        $display("FAIL drain: k=%0d we=%b addr=%0d data=%h expected 1/%0d/%h",
                 k, fb_we_out, fb_addr_out, fb_data_out, 1600 + k, 8'(8'hA0 + k));
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (fb_we_out !== 1'b0) $display("FAIL drain_end: we=%b expected 0", fb_we_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_clear();
    clear_in = 1'b1;
    step();
    clear_in = 1'b0;
    for (int e = 1; e <= 1001; e++) step();
    total_cnt++;
    if (fb_addr_out !== 16'd1000 || busy_out !== 1'b1)
      $display("FAIL pre_reset: addr=%0d busy=%b expected 1000/1", fb_addr_out, busy_out);
    else pass_cnt++;
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    total_cnt++;
    if (fb_addr_out !== 16'd0 || fb_data_out !== 8'd0 || fb_we_out !== 1'b0 || busy_out !== 1'b0)
      $display("FAIL midreset_port: addr=%0d data=%h we=%b busy=%b expected all 0",
               fb_addr_out, fb_data_out, fb_we_out, busy_out);
    else pass_cnt++;
    total_cnt++;
    if (drop_count_out !== 16'd0 || clip_count_out !== 16'd0)
      $display("FAIL midreset_counts: drop=%0d clip=%0d expected 0/0", drop_count_out, clip_count_out);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      step();
      total_cnt++;
      if (fb_we_out !== 1'b0 || busy_out !== 1'b0)
        $display("FAIL midreset_quiet: cycle %0d we=%b busy=%b expected 0/0", i, fb_we_out, busy_out);
      else pass_cnt++;
    end
    hcount_in = 11'd8; vcount_in = 10'd4; color_in = 8'h77; data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      total_cnt++;
      if (fb_we_out !== 1'b0) $display("FAIL midreset_early: we=%b at +%0d expected 0", fb_we_out, i);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (fb_we_out !== 1'b1 || fb_addr_out !== 16'd322 || fb_data_out !== 8'h77)
      $display("FAIL midreset_pixel: we=%b addr=%0d data=%h expected 1/322/77", fb_we_out, fb_addr_out, fb_data_out);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_clipping();
    test_streaming();
    test_clear_overflow();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
